zero_slot_decoder: RTL and testbench

- Write-side companion to the zero-priority encoder.
- Holds a registered occupancy mask whose lowest zero bit the encoder finds.
- Converts 5-bit slot indices, in the encoder's output format, into one-hot set/clear updates of that mask.
- Reports count, full/empty and a sticky protocol error; sits between the slot allocator/retire logic and the ZeroPriorityEnc input.

---
 rtl/zero_slot_decoder_if.sv | 31 +++
 rtl/zero_slot_decoder.sv | 109 ++++++++++
 tb/tb_zero_slot_decoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/zero_slot_decoder_if.sv
// Request/status bundle between the slot allocator/retire logic and the
// zero-slot decoder that feeds the zero-priority encoder.
interface zero_slot_decoder_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 5,
  parameter int CNT_W = 5
);
  logic             set_vld;
  logic [IDX_W-1:0] set_idx;
  logic             clr_vld;
  logic [IDX_W-1:0] clr_idx;
  logic             clr_all;
  logic             err_clr;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] onehot;
  logic             onehot_vld;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output set_vld, set_idx, clr_vld, clr_idx, clr_all, err_clr,
    input  mask, onehot, onehot_vld, count, full, empty, err
  );

  modport slave (
    input  set_vld, set_idx, clr_vld, clr_idx, clr_all, err_clr,
    output mask, onehot, onehot_vld, count, full, empty, err
  );
endinterface

// File: rtl/zero_slot_decoder.sv
// Occupancy mask keeper: turns slot indices into one-hot set/clear updates,
// tracks popcount/full/empty and a sticky protocol error.
module zero_slot_decoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 5,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  zero_slot_decoder_if.slave   bus
);

  // Out-of-range indices (including the encoder's "none" code) decode to zero.
  function automatic logic [WIDTH-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] one_v;
    one_v = {{(WIDTH-1){1'b0}}, 1'b1};
    if (idx < IDX_W'(WIDTH)) begin
      decode = one_v << idx;
    end else begin
      decode = {WIDTH{1'b0}};
    end
  endfunction

  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] onehot_r;
  logic             onehot_vld_r;
  logic [CNT_W-1:0] count_r;
  logic             full_r;
  logic             empty_r;
  logic             err_r;

  logic [WIDTH-1:0] clr_dec_s;
  logic [WIDTH-1:0] set_dec_s;
  logic [WIDTH-1:0] mask_after_clr_s;
  logic             clr_ok_s;
  logic             set_ok_s;
  logic             err_hit_s;
  logic [WIDTH-1:0] mask_nxt_s;
  logic [WIDTH-1:0] onehot_nxt_s;
  logic             onehot_vld_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             err_nxt_s;

  // Next-state: clear checked against current mask, set against post-clear mask.
  always_comb begin
    clr_dec_s        = decode(bus.clr_idx);
    set_dec_s        = decode(bus.set_idx);
    clr_ok_s         = bus.clr_vld && (|(mask_r & clr_dec_s));
    mask_after_clr_s = clr_ok_s ? (mask_r & ~clr_dec_s) : mask_r;
    set_ok_s         = bus.set_vld && (|set_dec_s) && !(|(mask_after_clr_s & set_dec_s));
    err_hit_s        = (bus.clr_vld && !clr_ok_s) || (bus.set_vld && !set_ok_s);
    mask_nxt_s       = mask_r;
    onehot_nxt_s     = onehot_r;
    onehot_vld_nxt_s = 1'b0;
    count_nxt_s      = count_r;
    if (bus.clr_all) begin
      mask_nxt_s  = {WIDTH{1'b0}};
      count_nxt_s = {CNT_W{1'b0}};
      err_hit_s   = 1'b0;
    end else begin
      mask_nxt_s  = set_ok_s ? (mask_after_clr_s | set_dec_s) : mask_after_clr_s;
      count_nxt_s = count_r - CNT_W'(clr_ok_s) + CNT_W'(set_ok_s);
      if (set_ok_s) begin
        onehot_nxt_s     = set_dec_s;
        onehot_vld_nxt_s = 1'b1;
      end else begin
        onehot_nxt_s     = onehot_r;
        onehot_vld_nxt_s = 1'b0;
      end
    end
    if (err_hit_s) begin
      err_nxt_s = 1'b1;
    end else if (bus.err_clr) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_r       <= {WIDTH{1'b0}};
      onehot_r     <= {WIDTH{1'b0}};
      onehot_vld_r <= 1'b0;
      count_r      <= {CNT_W{1'b0}};
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      err_r        <= 1'b0;
    end else begin
      mask_r       <= mask_nxt_s;
      onehot_r     <= onehot_nxt_s;
      onehot_vld_r <= onehot_vld_nxt_s;
      count_r      <= count_nxt_s;
      full_r       <= (count_nxt_s == CNT_W'(WIDTH));
      empty_r      <= (count_nxt_s == {CNT_W{1'b0}});
      err_r        <= err_nxt_s;
    end
  end

  assign bus.mask       = mask_r;
  assign bus.onehot     = onehot_r;
  assign bus.onehot_vld = onehot_vld_r;
  assign bus.count      = count_r;
  assign bus.full       = full_r;
  assign bus.empty      = empty_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_zero_slot_decoder.sv
// Directed + randomized bench for zero_slot_decoder against a slot-array model.
module tb_zero_slot_decoder;

  localparam int WIDTH = 16;
  localparam int IDX_W = 5;
  localparam int CNT_W = 5;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  // Reference model: one occupancy flag per slot plus last allocation.
  bit   occ [WIDTH];
  int   m_last;
  bit   m_ohv;
  bit   m_err;

  zero_slot_decoder_if #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  zero_slot_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_mask();
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = occ[i];
    return r;
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(occ[i]);
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] model_onehot();
    logic [WIDTH-1:0] r;
    r = '0;
    if (m_last >= 0) r[m_last] = 1'b1;
    return r;
  endfunction

  task automatic check_all(input string tag);
    int n;
    n = model_count();
    check({tag, ".mask"},       32'(bus.mask),       32'(model_mask()));
    check({tag, ".onehot"},     32'(bus.onehot),     32'(model_onehot()));
    check({tag, ".onehot_vld"}, 32'(bus.onehot_vld), 32'(m_ohv));
    check({tag, ".count"},      32'(bus.count),      32'(n));
    check({tag, ".full"},       32'(bus.full),       32'(n == WIDTH));
    check({tag, ".empty"},      32'(bus.empty),      32'(n == 0));
    check({tag, ".err"},        32'(bus.err),        32'(m_err));
  endtask

  task automatic model_reset();
    for (int i = 0; i < WIDTH; i++) occ[i] = 1'b0;
    m_last = -1;
    m_ohv  = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic step(input string tag, input bit sv, input int si, input bit cv,
                      input int ci, input bit ca, input bit ec);
    bit perr;
    bus.set_vld = sv;
    bus.set_idx = IDX_W'(si);
    bus.clr_vld = cv;
    bus.clr_idx = IDX_W'(ci);
    bus.clr_all = ca;
    bus.err_clr = ec;
    perr  = 1'b0;
    m_ohv = 1'b0;
    if (ca) begin
      for (int i = 0; i < WIDTH; i++) occ[i] = 1'b0;
    end else begin
      if (cv) begin
        if (ci < WIDTH && occ[ci]) occ[ci] = 1'b0;
        else perr = 1'b1;
      end
      if (sv) begin
        if (si < WIDTH && !occ[si]) begin
          occ[si] = 1'b1;
          m_last  = si;
          m_ohv   = 1'b1;
        end else begin
          perr = 1'b1;
        end
      end
    end
    if (perr) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    @(posedge clk);
    #1;
    bus.set_vld = 1'b0;
    bus.clr_vld = 1'b0;
    bus.clr_all = 1'b0;
    bus.err_clr = 1'b0;
    check_all(tag);
  endtask

  task automatic load_mask(input logic [WIDTH-1:0] val);
    step("load_clr_all", 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      if (val[i]) step("load_set", 1'b1, i, 1'b0, 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.set_vld = 1'b0;
    bus.set_idx = '0;
    bus.clr_vld = 1'b0;
    bus.clr_idx = '0;
    bus.clr_all = 1'b0;
    bus.err_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Walk all slots to full.
    for (int i = 0; i < WIDTH; i++) step("walk", 1'b1, i, 1'b0, 0, 1'b0, 1'b0);
    check("walk_full_const", 32'(bus.mask), 32'hFFFF);

    step("clr5", 1'b0, 0, 1'b1, 5, 1'b0, 1'b0);
    check("clr5_const", 32'(bus.mask), 32'hFFDF);
    step("set_clr5", 1'b1, 5, 1'b1, 5, 1'b0, 1'b0);
    step("realloc5", 1'b1, 5, 1'b1, 5, 1'b0, 1'b0);
    step("set_full", 1'b1, 9, 1'b0, 0, 1'b0, 1'b0);
    step("err_clr", 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    step("none_code", 1'b1, WIDTH, 1'b0, 0, 1'b0, 1'b1);
    step("clr_bad_idx", 1'b0, 0, 1'b1, 31, 1'b0, 1'b1);

    load_mask(16'h00F0);
    step("err_clr2", 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    step("set_dup4", 1'b1, 4, 1'b0, 0, 1'b0, 1'b0);
    step("clr_free0", 1'b0, 0, 1'b1, 0, 1'b0, 1'b0);

    load_mask(16'h1234);
    step("clr_all_mix", 1'b1, 3, 1'b1, 2, 1'b1, 1'b0);
    step("clr_empty", 1'b0, 0, 1'b1, 7, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    load_mask(16'hAAAA);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_set7", 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
    check("post_rst_const", 32'(bus.mask), 32'h0080);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int si;
      int ci;
      si = ($urandom_range(0, 9) == 0) ? int'($urandom_range(WIDTH, 31)) : int'($urandom_range(0, WIDTH - 1));
      ci = ($urandom_range(0, 9) == 0) ? int'($urandom_range(WIDTH, 31)) : int'($urandom_range(0, WIDTH - 1));
      step("rand", 1'($urandom_range(0, 3) != 0), si, 1'($urandom_range(0, 2) == 0), ci,
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
